lpc_reconstructor: RTL and testbench

Decoder-side counterpart of the encoder's FIR filter bank: rebuilds 16-bit PCM samples from a stream of FLAC LPC warm-up samples and residuals. Coefficients are loaded one by one, then a block of up to 65535 samples is reconstructed. Reconstruction uses a serial multiply-accumulate (MAC) over the selected order, computing x[n] = r[n] + ((sum of c[k]*x[n-k] for k=1..order) >>> shift). The block sits between the residual decoder and the PCM output buffer.

---
 rtl/lpc_reconstructor_if.sv | 27 ++
 rtl/lpc_reconstructor.sv | 111 +++++++++++
 tb/tb_lpc_reconstructor.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lpc_reconstructor_if.sv
// Handshake and data bus between the residual decoder, the LPC reconstructor
// and the PCM output buffer.
interface lpc_reconstructor_if;
  logic        iLoad;
  logic [3:0]  iM;
  logic [11:0] iCoeff;
  logic        iStart;
  logic [3:0]  iOrder;
  logic [3:0]  iShift;
  logic [15:0] iBlockSize;
  logic        iValid;
  logic [15:0] iResidual;
  logic        oReady;
  logic [15:0] oSample;
  logic        oValid;
  logic        oDone;

  modport master (
    output iLoad, iM, iCoeff, iStart, iOrder, iShift, iBlockSize, iValid, iResidual,
    input  oReady, oSample, oValid, oDone
  );

  modport slave (
    input  iLoad, iM, iCoeff, iStart, iOrder, iShift, iBlockSize, iValid, iResidual,
    output oReady, oSample, oValid, oDone
  );
endinterface

// File: rtl/lpc_reconstructor.sv
// FLAC LPC sample reconstruction: warm-up passthrough, then a serial MAC over
// the predictor order per residual, x[n] = r[n] + (sum c[k]*x[n-k] >>> shift).
module lpc_reconstructor (
  input logic               iClock,
  input logic               iReset,
  lpc_reconstructor_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WARMUP, WAIT, MAC, SUM} state_t;

  state_t             state;
  logic [12:1][11:0]  coeff;
  logic [12:1][15:0]  hist;
  logic signed [31:0] acc;
  logic [3:0]         idx;
  logic [3:0]         order_r;
  logic [3:0]         shift_r;
  logic [15:0]        size_r;
  logic [15:0]        out_count;
  logic [15:0]        res_r;

  logic               accept;
  logic [15:0]        count_nx;
  logic signed [27:0] prod;
  logic [15:0]        pred;
  logic [15:0]        sample;

  assign accept   = bus.iValid & bus.oReady;
  assign count_nx = out_count + 16'd1;
  assign prod     = 28'($signed(coeff[idx])) * 28'($signed(hist[idx]));
  // Only the low 16 bits survive, so the prediction is truncated before the add.
  assign pred     = 16'(acc >>> shift_r);
  assign sample   = res_r + pred;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state       <= IDLE;
      coeff       <= '0;
      hist        <= '0;
      acc         <= '0;
      idx         <= '0;
      order_r     <= '0;
      shift_r     <= '0;
      size_r      <= '0;
      out_count   <= '0;
      res_r       <= '0;
      bus.oSample <= '0;
      bus.oValid  <= 1'b0;
      bus.oReady  <= 1'b0;
      bus.oDone   <= 1'b0;
    end else begin
      bus.oValid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iLoad && bus.iM >= 4'd1 && bus.iM <= 4'd12)
            coeff[bus.iM] <= bus.iCoeff;
          if (bus.iStart && bus.iOrder >= 4'd1 && bus.iOrder <= 4'd12 &&
              bus.iBlockSize != 16'd0) begin
            order_r    <= bus.iOrder;
            shift_r    <= bus.iShift;
            size_r     <= bus.iBlockSize;
            hist       <= '0;
            out_count  <= '0;
            bus.oDone  <= 1'b0;
            bus.oReady <= 1'b1;
            state      <= WARMUP;
          end
        end
        WARMUP: if (accept) begin
          bus.oSample <= bus.iResidual;
          bus.oValid  <= 1'b1;
          hist        <= {hist[11:1], bus.iResidual};
          out_count   <= count_nx;
          // A block shorter than the order ends inside the warm-up phase.
          if (count_nx == size_r) begin
            bus.oReady <= 1'b0;
            bus.oDone  <= 1'b1;
            state      <= IDLE;
          end else if (count_nx == {12'd0, order_r}) begin
            state <= WAIT;
          end
        end
        WAIT: if (accept) begin
          res_r      <= bus.iResidual;
          acc        <= '0;
          idx        <= 4'd1;
          bus.oReady <= 1'b0;
          state      <= MAC;
        end
        MAC: begin
          acc <= acc + 32'(prod);
          idx <= idx + 4'd1;
          if (idx == order_r) state <= SUM;
        end
        SUM: begin
          bus.oSample <= sample;
          bus.oValid  <= 1'b1;
          hist        <= {hist[11:1], sample};
          out_count   <= count_nx;
          if (count_nx == size_r) begin
            bus.oDone <= 1'b1;
            state     <= IDLE;
          end else begin
            bus.oReady <= 1'b1;
            state      <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lpc_reconstructor.sv
// Directed and randomized checks of lpc_reconstructor against a sample-level
// LPC model (sum of products, floor shift, 16-bit wrap).
module tb_lpc_reconstructor;
  logic iClock = 1'b0;
  logic iReset = 1'b1;

  lpc_reconstructor_if bus();
  lpc_reconstructor dut (.iClock(iClock), .iReset(iReset), .bus(bus));

  always #5 iClock = ~iClock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge iClock) cyc <= cyc + 1;

  typedef struct {int val; int cyc; bit done;} obs_t;
  obs_t obs_q[$];
  obs_t mon_o;
  always @(negedge iClock) begin
    if (bus.oValid === 1'b1) begin
      mon_o.val  = int'($signed(bus.oSample));
      mon_o.cyc  = cyc;
      mon_o.done = bus.oDone;
      obs_q.push_back(mon_o);
    end
  end

  int coef_m [1:12];
  int in_q[$];
  int exp_q[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: x[n] = r[n] + floor(sum c[k]*x[n-k] / 2^shift), wrapped to 16 bits.
  function automatic void model(input int order, input int shift, input int size);
    longint s;
    int x[$];
    for (int n = 0; n < size; n++) begin
      if (n < order) x.push_back(in_q[n]);
      else begin
        s = 0;
        for (int k = 1; k <= order; k++) s += longint'(coef_m[k]) * longint'(x[n-k]);
        x.push_back(int'(shortint'(longint'(in_q[n]) + (s >>> shift))));
      end
    end
    exp_q = x;
  endfunction

  task automatic load(input int m, input int c);
    bus.iLoad = 1'b1; bus.iM = 4'(m); bus.iCoeff = 12'(c);
    @(negedge iClock);
    bus.iLoad = 1'b0;
    if (m >= 1 && m <= 12) coef_m[m] = c;
  endtask

  task automatic start(input int order, input int shift, input int size);
    bus.iStart = 1'b1; bus.iOrder = 4'(order); bus.iShift = 4'(shift);
    bus.iBlockSize = 16'(size);
    @(negedge iClock);
    bus.iStart = 1'b0;
  endtask

  // Returns the cycle number of the edge that accepted the value.
  task automatic send(input int v, output int acc_edge);
    int n = 0;
    bus.iValid = 1'b1; bus.iResidual = 16'(v);
    while (bus.oReady !== 1'b1 && n < 100) begin @(negedge iClock); n++; end
    if (bus.oReady !== 1'b1) begin
      chk("accept_timeout", longint'(bus.oReady), 1);
      acc_edge = -1000;
    end else begin
      @(negedge iClock);
      acc_edge = cyc;
    end
    bus.iValid = 1'b0;
  endtask

  task automatic run_block(input string tag, input int order, input int shift, input int size);
    int edges[$];
    int e;
    int n = 0;
    obs_q.delete();
    start(order, shift, size);
    for (int i = 0; i < size; i++) begin send(in_q[i], e); edges.push_back(e); end
    while (obs_q.size() < size && n < 40) begin @(negedge iClock); n++; end
    chk($sformatf("%s count", tag), obs_q.size(), size);
    for (int i = 0; i < size && i < obs_q.size(); i++) begin
      chk($sformatf("%s sample%0d", tag, i), obs_q[i].val, exp_q[i]);
      chk($sformatf("%s latency%0d", tag, i), obs_q[i].cyc - edges[i] + 1,
          (i < order) ? 1 : order + 2);
      chk($sformatf("%s done%0d", tag, i), obs_q[i].done, (i == size - 1) ? 1 : 0);
    end
    @(negedge iClock);
    chk({tag, " ready_after"}, bus.oReady, 0);
    chk({tag, " done_after"}, bus.oDone, 1);
  endtask

  initial begin
    int e;
    int n;
    int order, shift, size;
    bus.iLoad = 0; bus.iM = 0; bus.iCoeff = 0; bus.iStart = 0; bus.iOrder = 0;
    bus.iShift = 0; bus.iBlockSize = 0; bus.iValid = 0; bus.iResidual = 0;
    for (int k = 1; k <= 12; k++) coef_m[k] = 0;
    repeat (3) @(negedge iClock);
    iReset = 1'b0;
    chk("rst oSample", bus.oSample, 0);
    chk("rst oValid", bus.oValid, 0);
    chk("rst oReady", bus.oReady, 0);
    chk("rst oDone", bus.oDone, 0);

    // Order 1 basic
    load(1, 1);
    in_q = '{100, 5, -3, 7}; exp_q = '{100, 105, 102, 109};
    run_block("order1", 1, 0, 4);

    // Order 2 latency
    load(1, 2); load(2, -1);
    in_q = '{10, 20, 0, 0}; exp_q = '{10, 20, 30, 40};
    run_block("order2", 2, 0, 4);

    // Arithmetic shift floors toward minus infinity
    load(1, 3);
    in_q = '{-5, 0}; exp_q = '{-5, -8};
    run_block("ashift", 1, 1, 2);

    // Full order, maximum magnitude
    for (int k = 1; k <= 12; k++) load(k, 2047);
    in_q.delete(); exp_q.delete();
    for (int k = 0; k < 12; k++) begin in_q.push_back(32767); exp_q.push_back(32767); end
    in_q.push_back(0); exp_q.push_back(24563);
    run_block("order12", 12, 15, 13);

    // Two's-complement wrap
    load(1, 1);
    in_q = '{32767, 1}; exp_q = '{32767, -32768};
    run_block("wrap", 1, 0, 2);

    // Illegal starts are ignored: no ready, done stays up
    start(0, 0, 4);  repeat (2) @(negedge iClock);
    chk("illegal order0 ready", bus.oReady, 0);
    start(13, 0, 4); repeat (2) @(negedge iClock);
    chk("illegal order13 ready", bus.oReady, 0);
    start(1, 0, 0);  repeat (2) @(negedge iClock);
    chk("illegal size0 ready", bus.oReady, 0);
    chk("illegal done held", bus.oDone, 1);

    // Load during WAIT ignored, then reset mid-block
    load(1, 2);
    obs_q.delete();
    start(1, 0, 10);
    send(10, e);
    bus.iLoad = 1'b1; bus.iM = 4'd1; bus.iCoeff = 12'd5;
    @(negedge iClock);
    bus.iLoad = 1'b0;
    send(3, e);
    n = 0;
    while (obs_q.size() < 2 && n < 20) begin @(negedge iClock); n++; end
    chk("wait_load count", obs_q.size(), 2);
    if (obs_q.size() >= 2) chk("wait_load sample", obs_q[1].val, 23);
    iReset = 1'b1;
    @(negedge iClock);
    chk("midrst oSample", bus.oSample, 0);
    chk("midrst oValid", bus.oValid, 0);
    chk("midrst oReady", bus.oReady, 0);
    chk("midrst oDone", bus.oDone, 0);
    iReset = 1'b0;
    for (int k = 1; k <= 12; k++) coef_m[k] = 0;
    in_q = '{7, 5}; exp_q = '{7, 5};
    run_block("post_rst", 1, 0, 2);

    // Randomized blocks against the model, including sizes at or below the order
    for (int b = 0; b < 8; b++) begin
      order = int'($urandom_range(1, 12));
      shift = int'($urandom_range(0, 15));
      size  = int'($urandom_range(1, order + 6));
      for (int k = 1; k <= 12; k++) load(k, int'($urandom_range(0, 4095)) - 2048);
      in_q.delete();
      for (int i = 0; i < size; i++) in_q.push_back(int'($urandom_range(0, 65535)) - 32768);
      model(order, shift, size);
      run_block($sformatf("rand%0d", b), order, shift, size);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
